// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the mem_responder block.
//               - mem_state_t : per-channel request FSM states
//               - CNT_BITS    : latency counter width (covers LATENCY 1..15)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int CNT_BITS = 4;

endpackage
`default_nettype wire

// File: rtl/mem_responder_channel.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_channel
// Description : One request FSM (IDLE -> WAIT -> RESP -> IDLE) with latency
//               counter and captured request fields. Used for both read and
//               write channels; IS_WRITE selects whether data is captured.
// Ports       : clk, reset     - clock, async active-high reset
//               valid          - request valid from the initiator
//               address, data  - request address / write data
//               ready          - response valid (high while in RESP)
//               commit         - one-cycle strobe on the edge entering RESP
//               address_q      - address captured at acceptance
//               data_q         - write data captured at acceptance
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder_channel
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2,
  parameter bit IS_WRITE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 commit,
  output logic [ADDR_BITS-1:0] address_q,
  output logic [DATA_BITS-1:0] data_q
);

  localparam logic [CNT_BITS-1:0] C_CNT_LOAD = CNT_BITS'(LATENCY - 1);

  mem_state_t            r_state;
  mem_state_t            w_state_next;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  w_accept;

  assign w_accept = (r_state == IDLE) && valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (valid)          w_state_next = WAIT;
      WAIT:    if (r_cnt == '0)    w_state_next = RESP;
      RESP:    if (!valid)         w_state_next = IDLE;
      default:                     w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt  <= C_CNT_LOAD;
        r_addr <= address;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // The memory action (array write or read-data capture) happens on the
  // same edge that moves WAIT -> RESP, so commit is high during the last
  // WAIT cycle.
  assign commit    = (r_state == WAIT) && (r_cnt == '0);
  assign ready     = (r_state == RESP);
  assign address_q = r_addr;

  if (IS_WRITE) begin : g_wdata
    logic [DATA_BITS-1:0] r_data;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_data <= '0;
      else if (w_accept) r_data <= data;
    end
    assign data_q = r_data;
  end else begin : g_no_wdata
    assign data_q = '0;
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Multi-channel register-array memory target. Each channel has
//               an independent read and write FSM answering after LATENCY
//               cycles (legal 1..15). Holds the array, same-edge commit
//               arbitration and the backdoor init port.
// Ports       : clk, reset                      - clock, async active-high reset
//               read_valid/read_address         - per-channel read request
//               read_ready/read_data            - per-channel read response
//               write_valid/write_address/data  - per-channel write request
//               write_ready                     - per-channel write completion
//               init_write_enable/address/data  - backdoor preload port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]                 read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]                 write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]                 write_ready,
  input  logic                                init_write_enable,
  input  logic [ADDR_BITS-1:0]                init_address,
  input  logic [DATA_BITS-1:0]                init_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0]                 r_mem [DEPTH];
  logic [CHANNELS-1:0][DATA_BITS-1:0]   r_read_data;

  logic [CHANNELS-1:0]                  w_rd_commit;
  logic [CHANNELS-1:0][ADDR_BITS-1:0]   w_rd_addr;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   w_rd_data_unused;
  logic [CHANNELS-1:0]                  w_wr_commit;
  logic [CHANNELS-1:0][ADDR_BITS-1:0]   w_wr_addr;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   w_wr_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    mem_responder_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY),
      .IS_WRITE  (1'b0)
    ) u_rd (
      .clk       (clk),
      .reset     (reset),
      .valid     (read_valid[c]),
      .address   (read_address[c]),
      .data      ('0),
      .ready     (read_ready[c]),
      .commit    (w_rd_commit[c]),
      .address_q (w_rd_addr[c]),
      .data_q    (w_rd_data_unused[c])
    );

    mem_responder_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY),
      .IS_WRITE  (1'b1)
    ) u_wr (
      .clk       (clk),
      .reset     (reset),
      .valid     (write_valid[c]),
      .address   (write_address[c]),
      .data      (write_data[c]),
      .ready     (write_ready[c]),
      .commit    (w_wr_commit[c]),
      .address_q (w_wr_addr[c]),
      .data_q    (w_wr_data[c])
    );
  end

  // Priority comes from assignment order: init first, then channels from
  // highest index down, so the lowest committing channel's write lands last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (init_write_enable) r_mem[init_address] <= init_data;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (w_wr_commit[c]) r_mem[w_wr_addr[c]] <= w_wr_data[c];
      end
    end
  end

  // Reads sample the array before this edge's writes take effect, so a
  // same-edge read/write to one address returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_rd_commit[c]) r_read_data[c] <= r_mem[w_rd_addr[c]];
      end
    end
  end

  assign read_data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder. Three
//               instances (LATENCY 2, 1, 15) share all inputs; functional
//               checks use the LATENCY=2 instance, the sweep checks all.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      read_valid = '0;
  logic [3:0][7:0] read_address = '0;
  logic [3:0]      write_valid = '0;
  logic [3:0][7:0] write_address = '0;
  logic [3:0][7:0] write_data = '0;
  logic            init_write_enable = 1'b0;
  logic [7:0]      init_address = '0;
  logic [7:0]      init_data = '0;

  logic [3:0]      rr2, wr2, rr1, wr1, rr15, wr15;
  logic [3:0][7:0] rd2, rd1, rd15;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(rr2), .read_data(rd2),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(wr2),
    .init_write_enable(init_write_enable), .init_address(init_address),
    .init_data(init_data)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(rr1), .read_data(rd1),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(wr1),
    .init_write_enable(init_write_enable), .init_address(init_address),
    .init_data(init_data)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(rr15), .read_data(rd15),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(wr15),
    .init_write_enable(init_write_enable), .init_address(init_address),
    .init_data(init_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_wr(input logic [7:0] a, input logic [7:0] d);
    init_address = a;
    init_data = d;
    init_write_enable = 1'b1;
    tick();
    init_write_enable = 1'b0;
  endtask

  // Full read handshake on the LATENCY=2 instance, including hold and release.
  task automatic read_req(input int ch, input logic [7:0] a, input logic [7:0] exp);
    int k;
    read_address[ch] = a;
    read_valid[ch] = 1'b1;
    tick();                       // acceptance edge
    read_address[ch] = ~a;        // must be ignored after acceptance
    k = 0;
    while (!rr2[ch] && k < 40) begin
      tick();
      k++;
    end
    check("rd_latency", k, 2);
    check("rd_data", rd2[ch], exp);
    tick();
    check("rd_hold_ready", rr2[ch], 1);
    check("rd_hold_data", rd2[ch], exp);
    read_valid[ch] = 1'b0;
    tick();
    check("rd_release", rr2[ch], 0);
  endtask

  task automatic write_req(input int ch, input logic [7:0] a, input logic [7:0] d);
    int k;
    write_address[ch] = a;
    write_data[ch] = d;
    write_valid[ch] = 1'b1;
    tick();
    write_address[ch] = ~a;
    write_data[ch] = ~d;
    k = 0;
    while (!wr2[ch] && k < 40) begin
      tick();
      k++;
    end
    check("wr_latency", k, 2);
    write_valid[ch] = 1'b0;
    tick();
    check("wr_release", wr2[ch], 0);
  endtask

  initial begin
    int k;
    int lat1 [4];
    int lat2 [4];
    int lat15 [4];
    logic [7:0] dat1 [4];
    logic [7:0] dat15 [4];
    logic [7:0] sweep_val [4];

    // ---------------- reset state
    repeat (3) tick();
    check("reset_read_ready", rr2, 0);
    check("reset_write_ready", wr2, 0);
    check("reset_read_data", rd2, 0);
    reset = 1'b0;
    tick();

    // ---------------- reset mid-transaction
    init_wr(8'd3, 8'h77);
    read_address[1] = 8'd3;
    read_valid[1] = 1'b1;
    repeat (3) tick();
    check("pre_reset_ready1", rr2[1], 1);
    check("pre_reset_data1", rd2[1], 8'h77);
    read_address[0] = 8'd3;
    read_valid[0] = 1'b1;
    tick();                       // ch0 accepted, now in WAIT
    reset = 1'b1;
    #1;
    check("async_reset_ready", rr2, 0);
    check("async_reset_data", rd2, 0);
    read_valid = '0;
    tick();
    reset = 1'b0;
    tick();
    read_req(0, 8'd3, 8'h00);     // array cleared by reset

    // ---------------- init + read
    init_wr(8'd5, 8'h3C);
    read_req(2, 8'd5, 8'h3C);

    // ---------------- write then read
    write_req(1, 8'd10, 8'hA5);
    read_req(3, 8'd10, 8'hA5);

    // ---------------- same-edge write collision: lowest channel wins
    write_address[0] = 8'd7; write_data[0] = 8'h11;
    write_address[3] = 8'd7; write_data[3] = 8'h22;
    write_valid = 4'b1001;
    tick();
    k = 0;
    while (!wr2[0] && k < 40) begin
      tick();
      k++;
    end
    check("collision_ready", wr2, 4'b1001);
    write_valid = '0;
    tick();
    read_req(0, 8'd7, 8'h11);

    // ---------------- read/write race to one address: read sees old value
    init_wr(8'd9, 8'h01);
    write_address[0] = 8'd9; write_data[0] = 8'h02;
    read_address[1] = 8'd9;
    write_valid[0] = 1'b1;
    read_valid[1] = 1'b1;
    tick();
    k = 0;
    while (!rr2[1] && k < 40) begin
      tick();
      k++;
    end
    check("race_write_ready", wr2[0], 1);
    check("race_read_old", rd2[1], 8'h01);
    write_valid = '0;
    read_valid = '0;
    tick();
    read_req(2, 8'd9, 8'h02);

    // ---------------- latency sweep: all channels, three latencies
    repeat (20) tick();
    sweep_val[0] = 8'hA0; sweep_val[1] = 8'hB1;
    sweep_val[2] = 8'hC2; sweep_val[3] = 8'hD3;
    for (int c = 0; c < 4; c++) begin
      init_wr(8'(20 + c), sweep_val[c]);
      lat1[c] = -1; lat2[c] = -1; lat15[c] = -1;
      dat1[c] = '0; dat15[c] = '0;
    end
    for (int c = 0; c < 4; c++) read_address[c] = 8'(20 + c);
    read_valid = 4'hF;
    tick();                       // acceptance edge
    for (int e = 1; e <= 18; e++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (rr1[c] && lat1[c] < 0) begin lat1[c] = e; dat1[c] = rd1[c]; end
        if (rr2[c] && lat2[c] < 0) lat2[c] = e;
        if (rr15[c] && lat15[c] < 0) begin lat15[c] = e; dat15[c] = rd15[c]; end
      end
    end
    for (int c = 0; c < 4; c++) begin
      check("sweep_lat1", lat1[c], 1);
      check("sweep_lat2", lat2[c], 2);
      check("sweep_lat15", lat15[c], 15);
      check("sweep_data1", dat1[c], sweep_val[c]);
      check("sweep_data15", dat15[c], sweep_val[c]);
      check("sweep_data2", rd2[c], sweep_val[c]);
    end
    read_valid = '0;
    tick();
    check("sweep_release15", rr15, 0);
    check("sweep_release1", rr1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
